dpi_call_arbiter: RTL and testbench
===================================

Name: dpi_call_arbiter

Overview:
- Shares one export-style getter/setter resource between NUM_REQ requesters. The resource is a single WIDTH-bit value register driven on a top-level output, like an exported function's return.
- Each requester issues a GET (return current value) or SET (write, then return new value) call via a req/gnt/done handshake.
- Round-robin arbitration; calls execute serially with fixed LATENCY.
- Sits between requester logic and the shared value port at the top of the design.

Parameters:
- NUM_REQ, 4, number of requesters (>=2)
- WIDTH, 32, data width of the shared value
- LATENCY, 2, execute cycles per call (>=1)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  NUM_REQ  per-requester call request, level, held until done
- we  input  NUM_REQ  per-requester op select: 1=SET, 0=GET; sampled at grant
- wdata  input  NUM_REQ*WIDTH  per-requester write data, slice i = [i*WIDTH +: WIDTH]; sampled at grant
- gnt  output  NUM_REQ  one-hot grant, held from grant through done cycle
- done  output  NUM_REQ  one-cycle completion pulse to the granted requester
- rdata  output  WIDTH  call result, valid while done is high, holds until next done
- value  output  WIDTH  current contents of the shared register
- busy  output  1  high in EXEC and DONE

Behaviour:
- Reset (async assert, sync release): state=IDLE, gnt=0, done=0, rdata=0, value=0, busy=0, rr pointer=0, counter=0.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - With any req high at a clock edge: pick the winner by searching from the rr pointer upward, mod NUM_REQ.
  - Register gnt[winner], latch we[winner] and wdata slice, load counter=LATENCY-1, go to EXEC.
  - Set rr pointer = (winner+1) mod NUM_REQ.
  - With no req: stay in IDLE, all outputs hold.
- EXEC:
  - Decrement counter each cycle.
  - On the edge where counter==0:
    - SET: value <= latched wdata, rdata <= latched wdata.
    - GET: rdata <= value.
    - done[winner] <= 1; go to DONE.
  - EXEC lasts exactly LATENCY cycles.
- DONE:
  - One cycle. Next edge: done=0, gnt=0, go to IDLE.
- Timing and throughput:
  - Latency from req seen to done high is LATENCY+1 edges.
  - Minimum spacing between successive grants is LATENCY+2 cycles.
  - A still-asserted req re-arbitrates in IDLE.
- Requester side:
  - A call is committed at grant. Dropping req during EXEC/DONE does not abort; done still pulses.
  - Changing we/wdata after grant has no effect.
  - A requester must deassert req in the cycle after done, otherwise it is treated as a new call.
- Arbitration:
  - Simultaneous requests: exactly one grant; fairness guaranteed by the rr pointer.
  - No requester waits more than NUM_REQ-1 other calls.
- Invariants:
  - gnt is always one-hot or zero.
  - done is always a subset of gnt.
  - value changes only on a SET completion edge.
- Reset mid-operation returns to the reset state immediately. An in-flight SET is discarded and value=0.
- Counter width: $clog2(LATENCY+1), minimum 1 bit.

Decomposition:
- Shared package dpi_call_pkg:
  - state enum typedef (IDLE, EXEC, DONE)
  - op encoding constants OP_GET=1'b0, OP_SET=1'b1
- Sub-module rr_arbiter (combinational): inputs req and pointer; outputs one-hot winner and its index.
- FSM, counter and value register live in dpi_call_arbiter.

Test Plan:
- Reset, then idle 5 cycles -> value=0, rdata=0, gnt=0, done=0, busy=0 throughout.
- req[1]=1, we[1]=1, wdata slice1=32'hDEADBEEF (LATENCY=2):
  - gnt=4'b0010 one cycle later; done[1] pulses 3 edges after req seen.
  - rdata=value=32'hDEADBEEF; busy high 3 cycles.
- Then req[2] GET -> done[2] pulses with rdata=32'hDEADBEEF; value unchanged.
- req=4'b1111 held, all GET, pointer=0 -> grant order 0,1,2,3,0, each grant spaced 4 cycles.
- SET by req[0] (wdata=32'h5); req[0] dropped and wdata changed to 32'h9 during EXEC -> done[0] still pulses and value=32'h5.
- rst asserted mid-EXEC of a SET of 32'hA5A5A5A5 -> outputs immediately at reset values; value=0 after release; no done pulse.

Source files
------------

// File: rtl/dpi_call_arbiter_pkg.sv
// Shared types for the call arbiter: FSM state encoding and call opcodes.
package dpi_call_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_GET = 1'b0;
    localparam logic OP_SET = 1'b1;

endpackage

// File: rtl/dpi_call_arbiter_if.sv
// Requester-facing call bus plus the shared value/busy status.
interface dpi_call_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ-1:0]       we;
    logic [NUM_REQ*WIDTH-1:0] wdata;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_REQ-1:0]       done;
    logic [WIDTH-1:0]         rdata;
    logic [WIDTH-1:0]         value;
    logic                     busy;

    modport master (
        output req, we, wdata,
        input  gnt, done, rdata, value, busy
    );

    modport slave (
        input  req, we, wdata,
        output gnt, done, rdata, value, busy
    );
endinterface

// File: rtl/dpi_call_arbiter_rr.sv
// Combinational round-robin pick: first asserted request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win_oh,
    output logic [IDX_W-1:0]   win_idx
);
    logic found;
    int   k;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        k       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[k]) begin
                found     = 1'b1;
                win_oh[k] = 1'b1;
                win_idx   = IDX_W'(k);
            end
        end
    end
endmodule

// File: rtl/dpi_call_arbiter.sv
// Serialises GET/SET calls from NUM_REQ requesters onto one shared value register,
// granting round-robin and completing each call after a fixed LATENCY.
module dpi_call_arbiter
    import dpi_call_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst,
    dpi_call_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = ($clog2(LATENCY + 1) > 1) ? $clog2(LATENCY + 1) : 1;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [WIDTH-1:0]   rdata_q, rdata_d;
    logic [WIDTH-1:0]   value_q, value_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               op_q, op_d;
    logic [WIDTH-1:0]   wdata_q, wdata_d;

    logic [NUM_REQ-1:0] win_oh;
    logic [IDX_W-1:0]   win_idx;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req     (bus.req),
        .ptr     (ptr_q),
        .win_oh  (win_oh),
        .win_idx (win_idx)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = done_q;
        rdata_d = rdata_q;
        value_d = value_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        wdata_d = wdata_q;

        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    // The call is committed here: op and data are frozen for its lifetime.
                    gnt_d   = win_oh;
                    op_d    = bus.we[win_idx];
                    wdata_d = bus.wdata[win_idx*WIDTH +: WIDTH];
                    cnt_d   = CNT_W'(LATENCY - 1);
                    ptr_d   = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + IDX_W'(1);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    if (op_q == OP_SET) begin
                        value_d = wdata_q;
                        rdata_d = wdata_q;
                    end else begin
                        rdata_d = value_q;
                    end
                    done_d  = gnt_q;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                done_d  = '0;
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                done_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            rdata_q <= '0;
            value_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            value_q <= value_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Latched call operands are only read while a grant is active, so they need no reset.
    always_ff @(posedge clk) begin
        op_q    <= op_d;
        wdata_q <= wdata_d;
    end

    assign bus.gnt   = gnt_q;
    assign bus.done  = done_q;
    assign bus.rdata = rdata_q;
    assign bus.value = value_q;
    assign bus.busy  = (state_q != IDLE);
endmodule

// File: tb/tb_dpi_call_arbiter.sv
// Scoreboard bench for dpi_call_arbiter: expected grants/completions are queued as
// calls are issued and consumed by a negedge monitor.
module tb_dpi_call_arbiter;
    localparam int NR = 4;
    localparam int W  = 32;

    typedef struct {
        logic [NR-1:0] d;
        logic [W-1:0]  rd;
        logic [W-1:0]  v;
    } done_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    logic [NR-1:0] exp_gnt_q[$];
    done_t         exp_done_q[$];
    int            gnt_cyc[$];
    logic [NR-1:0] prev_gnt = '0;

    dpi_call_arbiter_if #(.NUM_REQ(NR), .WIDTH(W)) bus();

    dpi_call_arbiter #(.NUM_REQ(NR), .WIDTH(W), .LATENCY(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // Monitor: consume queued expectations as grants and completions appear.
    always @(negedge clk) begin
        done_t e;
        if (rst) begin
            prev_gnt = '0;
        end else begin
            if (bus.gnt != '0 && prev_gnt == '0) begin
                if (exp_gnt_q.size() == 0) check("gnt_unexpected", {60'd0, bus.gnt}, 64'd0);
                else check("gnt_order", {60'd0, bus.gnt}, {60'd0, exp_gnt_q.pop_front()});
                gnt_cyc.push_back(cyc);
            end
            if (bus.done != '0) begin
                if (exp_done_q.size() == 0) begin
                    check("done_unexpected", {60'd0, bus.done}, 64'd0);
                end else begin
                    e = exp_done_q.pop_front();
                    check("done_vec", {60'd0, bus.done}, {60'd0, e.d});
                    check("done_rdata", {32'd0, bus.rdata}, {32'd0, e.rd});
                    check("done_value", {32'd0, bus.value}, {32'd0, e.v});
                end
            end
            check("gnt_onehot0", {63'd0, $onehot0(bus.gnt)}, 64'd1);
            check("done_in_gnt", {60'd0, bus.done & ~bus.gnt}, 64'd0);
            prev_gnt = bus.gnt;
        end
    end

    // Issue one call and wait for its completion; optionally drop req and scramble
    // operands during EXEC to show the call is committed at grant.
    task automatic call(input int idx, input logic w, input logic [W-1:0] d,
                        input logic [W-1:0] exp_rd, input logic [W-1:0] exp_v,
                        input bit drop_early, input logic [W-1:0] d_late);
        int lat;
        int busy_n;
        done_t e;
        @(negedge clk);
        bus.req[idx] = 1'b1;
        bus.we[idx]  = w;
        bus.wdata[idx*W +: W] = d;
        exp_gnt_q.push_back(NR'(1) << idx);
        e.d = NR'(1) << idx; e.rd = exp_rd; e.v = exp_v;
        exp_done_q.push_back(e);
        lat = 0;
        busy_n = 0;
        while (!bus.done[idx] && lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus.busy) busy_n++;
            if (lat == 1) check("gnt_after_1", {60'd0, bus.gnt}, {60'd0, NR'(1) << idx});
            if (drop_early && lat == 1) begin
                bus.req[idx] = 1'b0;
                bus.we[idx]  = ~w;
                bus.wdata[idx*W +: W] = d_late;
            end
        end
        check("done_latency", 64'(lat), 64'd3);
        bus.req[idx] = 1'b0;
        @(negedge clk);
        check("busy_cycles", 64'(busy_n), 64'd3);
        check("busy_low_after", {63'd0, bus.busy}, 64'd0);
        check("done_cleared", {60'd0, bus.done}, 64'd0);
    endtask

    initial begin
        int base;
        int n;
        done_t e;
        bus.req   = '0;
        bus.we    = '0;
        bus.wdata = '0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_value", {32'd0, bus.value}, 64'd0);
            check("idle_rdata", {32'd0, bus.rdata}, 64'd0);
            check("idle_gnt", {60'd0, bus.gnt}, 64'd0);
            check("idle_done", {60'd0, bus.done}, 64'd0);
            check("idle_busy", {63'd0, bus.busy}, 64'd0);
        end

        call(1, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 32'h0);
        call(2, 1'b0, 32'h00001234, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 32'h0);
        call(3, 1'b0, 32'h00000000, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 32'h0);

        // All four requesting GET with the pointer back at 0.
        @(negedge clk);
        base = gnt_cyc.size();
        for (int i = 0; i < 5; i++) begin
            exp_gnt_q.push_back(NR'(1) << (i % NR));
            e.d = NR'(1) << (i % NR); e.rd = 32'hDEADBEEF; e.v = 32'hDEADBEEF;
            exp_done_q.push_back(e);
        end
        bus.we  = '0;
        bus.req = '1;
        n = 0;
        while (!(bus.done[0] && gnt_cyc.size() >= base + 5) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("stream_timeout", {63'd0, (n >= 60)}, 64'd0);
        bus.req = '0;
        repeat (4) @(negedge clk);
        check("stream_grants", 64'(gnt_cyc.size() - base), 64'd5);
        if (gnt_cyc.size() >= base + 5)
            for (int i = 0; i < 4; i++)
                check("grant_spacing", 64'(gnt_cyc[base+i+1] - gnt_cyc[base+i]), 64'd4);
        check("stream_done_left", 64'(exp_done_q.size()), 64'd0);

        call(0, 1'b1, 32'h00000005, 32'h00000005, 32'h00000005, 1'b1, 32'h00000009);
        repeat (2) @(negedge clk);
        check("value_after_drop", {32'd0, bus.value}, 64'h5);

        // Reset lands in the middle of a SET's EXEC phase.
        @(negedge clk);
        bus.req[2] = 1'b1;
        bus.we[2]  = 1'b1;
        bus.wdata[2*W +: W] = 32'hA5A5A5A5;
        exp_gnt_q.push_back(4'b0100);
        @(negedge clk);
        check("mid_gnt", {60'd0, bus.gnt}, 64'h4);
        check("mid_busy", {63'd0, bus.busy}, 64'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_gnt", {60'd0, bus.gnt}, 64'd0);
        check("rst_done", {60'd0, bus.done}, 64'd0);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_value", {32'd0, bus.value}, 64'd0);
        check("rst_rdata", {32'd0, bus.rdata}, 64'd0);
        bus.req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("post_rst_value", {32'd0, bus.value}, 64'd0);
        check("post_rst_rdata", {32'd0, bus.rdata}, 64'd0);
        check("post_rst_busy", {63'd0, bus.busy}, 64'd0);
        check("gnt_q_left", 64'(exp_gnt_q.size()), 64'd0);
        check("done_q_left", 64'(exp_done_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
